calc_entry_sequencer: RTL and testbench
=======================================

Name: calc_entry_sequencer

Overview:
Operand-entry front end for the 3-bit signed calculator. It sits directly upstream of the combinational sign-magnitude adder/subtractor.
- Captures operand A, operand B and the add/sub select from switches, one debounced ENTER press at a time.
- Drives the held operands into the adder.
- Registers the adder's 4-bit sign-magnitude result and holds it for display.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before a button level is accepted (>=2)
SYNC_STAGES, 2, flip-flop synchronizer depth on each raw button input (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
sw_val  input  3  operand switches, sign-magnitude: bit2 sign, bits1:0 magnitude
sw_op  input  1  operation switch: 0 add, 1 subtract
btn_enter  input  1  raw asynchronous ENTER button, active-high
btn_clear  input  1  raw asynchronous CLEAR button, active-high
op_a  output  3  held operand A to adder
op_b  output  3  held operand B to adder
op_sub  output  1  held operation select to adder
sum_in  input  4  adder result, sign-magnitude: bit3 sign, bits2:0 magnitude
result  output  4  registered, normalized result
result_valid  output  1  high while result holds a completed computation
state_o  output  3  current FSM state encoding, for LEDs/debug

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous, active-low. On assertion, with no clock required:
  - op_a=0, op_b=0, op_sub=0, result=0, result_valid=0.
  - state=GET_A; synchronizers and debounce counters cleared, stable levels 0.
- Button conditioning, per button:
  - SYNC_STAGES-flop synchronizer.
  - Counter increments while the synced level differs from the stable level; it resets to 0 whenever they match.
  - On reaching DEBOUNCE_CYCLES-1, the stable level takes the synced level and the counter clears.
  - A 0->1 transition of the stable level gives a one-cycle pulse (enter_p / clear_p).
  - Holding a button produces exactly one pulse.
- FSM states (encoding): GET_A=0, GET_B=1, GET_OP=2, COMPUTE=3, SHOW=4.
  - GET_A: on enter_p, op_a <= norm(sw_val), clear result_valid; -> GET_B.
  - GET_B: on enter_p, op_b <= norm(sw_val); -> GET_OP.
  - GET_OP: on enter_p, op_sub <= sw_op; -> COMPUTE.
  - COMPUTE: unconditional, one cycle (adder settle); at end of cycle result <= normr(sum_in), result_valid <= 1; -> SHOW.
  - SHOW: result and operands held; on enter_p -> GET_A, result_valid <= 0, result keeps its old value until the next COMPUTE.
- Any state: clear_p -> GET_A; op_a, op_b, op_sub, result and result_valid all zeroed. Clear has priority over a simultaneous enter_p.
- enter_p arriving in COMPUTE is ignored (not queued).
- Normalization:
  - norm(3'b100) = 3'b000 (negative zero folds to +0); other values pass through.
  - normr(4'b1000) = 4'b0000; other values pass through.
- Range: operands -3..+3; result -6..+6. The result magnitude fits 3 bits; no overflow flag.
- result_valid rises exactly 1 cycle after entering COMPUTE, i.e. 2 clk edges after the GET_OP enter_p.

Decomposition:
- Package calc_pkg holds:
  - state enum (3-bit) and its encodings;
  - OPERAND_W=3, RESULT_W=4;
  - NEG_ZERO_OPERAND=3'b100, NEG_ZERO_RESULT=4'b1000.
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse), parameterized by SYNC_STAGES/DEBOUNCE_CYCLES, instantiated twice (enter, clear).

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, and a behavioural sign-magnitude adder on op_a/op_b/op_sub -> sum_in.
1. Assert rst_n=0 mid-run in SHOW with result=0110 -> all outputs 0 and state_o=0 immediately, before the next clk edge.
2. Add: sw_val=011 ENTER, sw_val=110 ENTER, sw_op=0 ENTER -> op_a=011, op_b=110, state_o 3 then 4; result=0001, result_valid=1 one cycle after COMPUTE.
3. Subtract: 011, 111, op=1 -> result=0110 (+6); then -3-(+3): 111, 011, op=1 -> result=1110 (-6).
4. Bounce: btn_enter high 2 cycles -> no state change; high 10 cycles -> exactly one advance; held through two FSM states -> still one advance.
5. Negative zero: sw_val=100 in GET_A -> op_a=000. 001 - 001 -> sum_in 1000 from adder model -> result=0000.
6. In GET_B, clear_p and enter_p in the same cycle -> state GET_A, op_a=000, op_b unchanged at 000, result_valid=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types, widths and normalization helpers for the calculator
// operand-entry front end.
package calc_pkg;

  localparam int OPERAND_W = 3;
  localparam int RESULT_W  = 4;

  localparam logic [OPERAND_W-1:0] NEG_ZERO_OPERAND = 3'b100;
  localparam logic [RESULT_W-1:0]  NEG_ZERO_RESULT  = 4'b1000;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    COMPUTE = 3'd3,
    SHOW    = 3'd4
  } state_t;

  // Sign-magnitude negative zero folds to +0 so downstream logic sees one zero.
  function automatic logic [OPERAND_W-1:0] norm_operand(input logic [OPERAND_W-1:0] v);
    return (v == NEG_ZERO_OPERAND) ? '0 : v;
  endfunction

  function automatic logic [RESULT_W-1:0] norm_result(input logic [RESULT_W-1:0] v);
    return (v == NEG_ZERO_RESULT) ? '0 : v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: multi-flop synchronizer, stability counter and a
// single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   level;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // The pulse is raised on the same edge the stable level rises, so it
  // coincides with the first cycle the press is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      pulse  <= 1'b0;
      if (synced != level) begin
        if (cnt == CNT_MAX) begin
          level <= synced;
          cnt   <= '0;
          pulse <= synced;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_entry_sequencer.sv
// Operand-entry sequencer: captures A, B and the operation on debounced
// ENTER presses, feeds the adder, and holds its normalized result.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] sw_val,
  input  logic                 sw_op,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  output logic                 op_sub,
  input  logic [RESULT_W-1:0]  sum_in,
  output logic [RESULT_W-1:0]  result,
  output logic                 result_valid,
  output logic [2:0]           state_o
);

  state_t               state, state_n;
  logic [OPERAND_W-1:0] op_a_n, op_b_n;
  logic                 op_sub_n;
  logic [RESULT_W-1:0]  result_n;
  logic                 result_valid_n;
  logic                 enter_p, clear_p;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_enter),
    .pulse   (enter_p)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clear),
    .pulse   (clear_p)
  );

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GET_A;
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      op_a         <= op_a_n;
      op_b         <= op_b_n;
      op_sub       <= op_sub_n;
      result       <= result_n;
      result_valid <= result_valid_n;
    end
  end

  // result_valid is a level, not a handshake: high from the end of COMPUTE
  // until the next operand entry starts or CLEAR is accepted.
  always_comb begin
    state_n        = state;
    op_a_n         = op_a;
    op_b_n         = op_b;
    op_sub_n       = op_sub;
    result_n       = result;
    result_valid_n = result_valid;
    if (clear_p) begin
      state_n        = GET_A;
      op_a_n         = '0;
      op_b_n         = '0;
      op_sub_n       = 1'b0;
      result_n       = '0;
      result_valid_n = 1'b0;
    end else begin
      case (state)
        GET_A: if (enter_p) begin
          op_a_n         = norm_operand(sw_val);
          result_valid_n = 1'b0;
          state_n        = GET_B;
        end
        GET_B: if (enter_p) begin
          op_b_n  = norm_operand(sw_val);
          state_n = GET_OP;
        end
        GET_OP: if (enter_p) begin
          op_sub_n = sw_op;
          state_n  = COMPUTE;
        end
        // One cycle for the combinational adder to settle; ENTER is dropped here.
        COMPUTE: begin
          result_n       = norm_result(sum_in);
          result_valid_n = 1'b1;
          state_n        = SHOW;
        end
        SHOW: if (enter_p) begin
          result_valid_n = 1'b0;
          state_n        = GET_A;
        end
        default: state_n = GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer with a behavioural sign-magnitude
// adder closing the loop from op_a/op_b/op_sub to sum_in.
module tb_calc_entry_sequencer;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_val;
  logic       sw_op;
  logic       btn_enter;
  logic       btn_clear;
  logic [2:0] op_a;
  logic [2:0] op_b;
  logic       op_sub;
  logic [3:0] sum_in;
  logic [3:0] result;
  logic       result_valid;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  calc_entry_sequencer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_val       (sw_val),
    .sw_op        (sw_op),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_sub       (op_sub),
    .sum_in       (sum_in),
    .result       (result),
    .result_valid (result_valid),
    .state_o      (state_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // Sign-magnitude adder: equal magnitudes with opposite effective signs take
  // the subtrahend's sign, so 1-1 yields negative zero (1000).
  always_comb begin
    logic       sa, sb;
    logic [2:0] ma, mb;
    sa = op_a[2];
    sb = op_b[2] ^ op_sub;
    ma = {1'b0, op_a[1:0]};
    mb = {1'b0, op_b[1:0]};
    if (sa == sb)     sum_in = {sa, ma + mb};
    else if (ma > mb) sum_in = {sa, ma - mb};
    else              sum_in = {sb, mb - ma};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic press(input logic e, input logic c, input int hold);
    btn_enter = e;
    btn_clear = c;
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic enter_val(input logic [2:0] v);
    sw_val = v;
    press(1'b1, 1'b0, 10);
  endtask

  task automatic run_calc(input logic [2:0] a, input logic [2:0] b, input logic op,
                          input logic [2:0] exp_a, input logic [2:0] exp_b,
                          input logic [3:0] exp_r);
    int waited;
    enter_val(a);
    check("op_a", op_a, exp_a);
    enter_val(b);
    check("op_b", op_b, exp_b);
    check("state_get_op", state_o, 3'd2);
    sw_op = op;
    exp_q.push_back(exp_r);
    btn_enter = 1'b1;
    waited = 0;
    while (state_o != 3'd3 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("enter_compute", state_o, 3'd3);
    check("valid_low_in_compute", result_valid, 1'b0);
    check("op_sub", op_sub, op);
    @(negedge clk);
    check("state_show", state_o, 3'd4);
    check("valid_after_compute", result_valid, 1'b1);
    check("result", result, exp_q.pop_front());
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    check("held_in_show", state_o, 3'd4);
  endtask

  initial begin
    rst_n     = 1'b0;
    sw_val    = 3'b000;
    sw_op     = 1'b0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    #1;
    check("rst_op_a", op_a, 3'd0);
    check("rst_op_b", op_b, 3'd0);
    check("rst_op_sub", op_sub, 1'b0);
    check("rst_result", result, 4'd0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_state", state_o, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // +3 + -2 = +1
    run_calc(3'b011, 3'b110, 1'b0, 3'b011, 3'b110, 4'b0001);
    press(1'b1, 1'b0, 10);
    check("show_to_get_a", state_o, 3'd0);
    check("valid_drop", result_valid, 1'b0);
    check("result_kept", result, 4'b0001);

    // +3 - (-3) = +6
    run_calc(3'b011, 3'b111, 1'b1, 3'b011, 3'b111, 4'b0110);

    // asynchronous reset mid-run, away from the clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_op_a", op_a, 3'd0);
    check("arst_op_b", op_b, 3'd0);
    check("arst_op_sub", op_sub, 1'b0);
    check("arst_result", result, 4'd0);
    check("arst_valid", result_valid, 1'b0);
    check("arst_state", state_o, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // -3 - (+3) = -6
    run_calc(3'b111, 3'b011, 1'b1, 3'b111, 3'b011, 4'b1110);
    press(1'b1, 1'b0, 10);
    check("back_to_get_a", state_o, 3'd0);

    // bounce and hold behaviour
    sw_val = 3'b001;
    press(1'b1, 1'b0, 2);
    check("short_glitch", state_o, 3'd0);
    press(1'b1, 1'b0, 10);
    check("one_advance", state_o, 3'd1);
    check("bounce_op_a", op_a, 3'b001);
    press(1'b1, 1'b0, 40);
    check("long_hold", state_o, 3'd2);
    check("hold_op_b", op_b, 3'b001);
    press(1'b0, 1'b1, 10);
    check("clear_state", state_o, 3'd0);
    check("clear_op_a", op_a, 3'd0);
    check("clear_op_b", op_b, 3'd0);

    // negative zero folding
    enter_val(3'b100);
    check("negzero_op_a", op_a, 3'b000);
    check("negzero_state", state_o, 3'd1);
    press(1'b0, 1'b1, 10);
    run_calc(3'b001, 3'b001, 1'b1, 3'b001, 3'b001, 4'b0000);

    // clear wins over simultaneous enter in GET_B
    press(1'b0, 1'b1, 10);
    enter_val(3'b010);
    check("pre_clr_op_a", op_a, 3'b010);
    check("pre_clr_state", state_o, 3'd1);
    press(1'b1, 1'b1, 10);
    check("clr_pri_state", state_o, 3'd0);
    check("clr_pri_op_a", op_a, 3'd0);
    check("clr_pri_op_b", op_b, 3'd0);
    check("clr_pri_valid", result_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
